mmu_instr_dispatcher: RTL and testbench
=======================================

MMU_INSTR_DISPATCHER -- requirements
Module: mmu_instr_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, instruction queue depth (power of two, >=2).
REQ-002 SHALL have parameter MATRIX_WIDTH, default 14, systolic array width; not used in logic, passed for consistency.
REQ-003 SHALL have input clk, 1 bit: the single clock; all state on posedge clk.
REQ-004 SHALL have input rst, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input enable, 1 bit: 0 freezes issue; queue accepts still.
REQ-006 SHALL have input in_instr, instr_type: instruction from the host side.
REQ-007 SHALL have input in_valid, 1 bit: in_instr valid.
REQ-008 SHALL have output in_ready, 1 bit: queue can accept this cycle.
REQ-009 SHALL have output instr, instr_type: instruction to the matrix multiply unit controller.
REQ-010 SHALL have output instr_enable, 1 bit: single-cycle issue strobe to the controller.
REQ-011 SHALL have input busy, 1 bit: controller busy.
REQ-012 SHALL have input resource_busy, 1 bit: controller resources in use.
REQ-013 SHALL have output idle, 1 bit: queue empty, FSM IDLE, busy=0.
REQ-014 SHALL have output drop_err, 1 bit: one-cycle pulse when an instruction is discarded.
REQ-015 SHALL have output issued_count, 16 bits: instructions issued since reset.

Function
REQ-016 SHALL accept in_instr on a posedge where in_valid=1 and in_ready=1; in_ready = queue not full.
REQ-017 SHALL discard, at acceptance, any instruction whose opcode[7:4] != 4'b0010 or whose length = 0, never enqueue it, and pulse drop_err the next cycle.
REQ-018 SHALL implement a FIFO_DEPTH circular queue; read and write pointers wrap modulo FIFO_DEPTH; simultaneous enqueue and dequeue when full is not allowed (in_ready=0 when full, regardless of dequeue).
REQ-019 SHALL use FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> ISSUE when enable=1, queue non-empty, busy=0 and resource_busy=0.
REQ-021 In ISSUE, SHALL drive instr = queue head, instr_enable=1 for exactly one cycle, pop the head and increment issued_count (wrapping 16'hFFFF -> 0); then go to WAIT_BUSY.
REQ-022 WAIT_BUSY SHALL last exactly one cycle (controller busy latency), then go to WAIT_DONE.
REQ-023 WAIT_DONE -> IDLE on the first cycle where busy=0.
REQ-024 instr SHALL hold the last issued value outside ISSUE; instr_enable=0 in every state except ISSUE.
REQ-025 enable=0 SHALL only block the IDLE -> ISSUE transition; an issue in progress completes.
REQ-026 Issue-to-issue minimum spacing SHALL be 4 cycles (ISSUE, WAIT_BUSY, WAIT_DONE with busy=0, IDLE).
REQ-027 Arriving and issuing in the same cycle SHALL both take effect; empty-queue arrivals SHALL NOT bypass the queue (minimum enqueue-to-instr_enable latency 2 cycles).

Reset
REQ-028 On rst=0, SHALL asynchronously clear the queue and go to IDLE; instr=INIT_INSTR, instr_enable=0, in_ready=1, drop_err=0, issued_count=0, idle=1 once busy=0.
REQ-029 Reset mid-operation SHALL discard every queued instruction with no further instr_enable and no drop_err.

Verification
REQ-030 Single issue: enqueue {opcode 8'h23, length 29, acc_addr 16'h0049, buffer_addr 24'h009463}, busy=0 -> instr_enable high one cycle, 2 cycles after enqueue, with instr equal to the input; issued_count=1.
REQ-031 Back-to-back: enqueue 8'h23 then 8'h20 (length 14, acc_addr 16'h0006, buffer_addr 24'h0000AB); model busy high 1 cycle after each issue for 20 cycles -> second issue only after busy falls, in order.
REQ-032 Full queue: with busy=1 held, enqueue 5 valid instructions -> first 4 accepted, in_ready=0 on the 5th; after busy=0, 4 issues in FIFO order.
REQ-033 Drop: enqueue opcode 8'h10, then 8'h20 with length 0 -> drop_err pulses twice, no instr_enable, issued_count unchanged.
REQ-034 Gating: enable=0 with 2 queued -> no issue; resource_busy=1 with enable=1 -> no issue; release both -> issues resume.
REQ-035 Reset mid-operation: assert rst=0 in WAIT_DONE with 3 queued -> all outputs take reset values immediately; no issue after release until a new enqueue.

Source files
------------

// File: rtl/mmu_instr_dispatcher_if.sv
// Host/controller-facing signal bundle of the matrix-multiply instruction dispatcher.
// Instruction layout (64 bits): {opcode[63:56], length[55:40], acc_addr[39:24], buffer_addr[23:0]}.
interface mmu_instr_dispatcher_if;
    // Handshake: in_instr is transferred on a rising clk edge where in_valid and in_ready are
    // both 1; in_ready depends only on queue occupancy, never on in_valid.
    logic        enable;
    logic [63:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] instr;
    logic        instr_enable;
    logic        busy;
    logic        resource_busy;
    logic        idle;
    logic        drop_err;
    logic [15:0] issued_count;
    logic [1:0]  dbg_state;

    modport master (
        input  enable, in_instr, in_valid, busy, resource_busy,
        output in_ready, instr, instr_enable, idle, drop_err, issued_count, dbg_state
    );

    modport slave (
        output enable, in_instr, in_valid, busy, resource_busy,
        input  in_ready, instr, instr_enable, idle, drop_err, issued_count, dbg_state
    );
endinterface

// File: rtl/mmu_instr_dispatcher.sv
// Queues host instructions and issues them one at a time to the matrix-multiply controller,
// pacing each issue on the controller's busy/resource_busy feedback.
module mmu_instr_dispatcher #(
    parameter int FIFO_DEPTH   = 4,
    parameter int MATRIX_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    mmu_instr_dispatcher_if.master bus
);
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] CNT_ONE    = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [63:0] INIT_INSTR = 64'h0;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MATRIX_WIDTH < 1) begin : g_bad_params
        $error("mmu_instr_dispatcher: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [63:0]   instr_q;
    logic          drop_q;
    logic [15:0]   issued_q;

    logic accept, legal, push, pop, start;

    // Only opcode class 0x2X with a non-zero length is executable; anything else is dropped.
    assign accept = bus.in_valid && bus.in_ready;
    assign legal  = (bus.in_instr[63:60] == 4'b0010) && (bus.in_instr[55:40] != 16'h0);
    assign push   = accept && legal;
    assign pop    = (state_q == ISSUE);
    assign start  = (state_q == IDLE) && bus.enable && (cnt_q != '0)
                    && !bus.busy && !bus.resource_busy;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            instr_q  <= INIT_INSTR;
            drop_q   <= 1'b0;
            issued_q <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= accept && !legal;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            // Head is latched on entry to ISSUE so instr is valid during the strobe and held after.
            if (start) begin
                instr_q <= mem_q[rd_ptr_q];
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                issued_q <= issued_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_instr;
        end
    end

    assign bus.in_ready     = (cnt_q != FULL_CNT);
    assign bus.instr        = instr_q;
    assign bus.instr_enable = (state_q == ISSUE);
    assign bus.idle         = (state_q == IDLE) && (cnt_q == '0) && !bus.busy;
    assign bus.drop_err     = drop_q;
    assign bus.issued_count = issued_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_mmu_instr_dispatcher.sv
// Self-checking bench for mmu_instr_dispatcher: directed scenarios plus randomized traffic
// compared every cycle against a queue/cycle-arithmetic model.
module tb_mmu_instr_dispatcher;
  localparam int DEPTH = 4;
  localparam int BIG = 32'h7fff_ffff;

  logic clk;
  logic rst;
  mmu_instr_dispatcher_if bus();

  mmu_instr_dispatcher #(.FIFO_DEPTH(DEPTH), .MATRIX_WIDTH(14)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  logic [63:0] iss_log[$];
  int iss_cyc[$];
  int drop_seen = 0;
  bit force_busy = 0;
  int ctrl_len = 3;
  int busy_left = 0;
  bit cmp_on = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- helpers ----------------
  function automatic logic [63:0] mk(input logic [7:0] op, input logic [15:0] len,
                                     input logic [15:0] acc, input logic [23:0] bufa);
    return {op, len, acc, bufa};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic try_send(input logic [63:0] x, output bit acc);
    bus.in_valid = 1'b1;
    bus.in_instr = x;
    @(negedge clk);
    acc = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget);
    int k = 0;
    while (iss_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("issue_wait_timeout", iss_log.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!bus.idle && k < budget) begin
      tick();
      k++;
    end
    chk("idle_wait_timeout", bus.idle, 1);
  endtask

  // ---------------- controller model: busy follows each issue ----------------
  initial begin
    bit ie;
    bus.busy = 1'b0;
    forever begin
      @(negedge clk);
      ie = bus.instr_enable;
      @(posedge clk);
      #1;
      if (!rst) busy_left = 0;
      else if (ie) busy_left = ctrl_len;
      else if (busy_left > 0) busy_left--;
      bus.busy = force_busy || (busy_left > 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.instr_enable) begin
          iss_log.push_back(bus.instr);
          iss_cyc.push_back(cyc_cnt);
        end
        if (bus.drop_err) drop_seen++;
      end
    end
  end

  // ---------------- reference model ----------------
  // Cycle n is the period following the n-th rising edge. An issue occupies one cycle; the
  // dispatcher is free again the cycle after the first busy-low cycle at least two cycles later.
  logic [63:0] mq[$];
  int m_cyc = 0;
  int free_from = 0;
  int watch_from = 0;
  bit watching = 0;
  int issue_cyc = -1;
  logic [63:0] e_instr = '0;
  logic [15:0] e_cnt = '0;
  bit e_drop = 0;
  bit e_ie = 0;
  bit e_ready = 1;
  bit e_idle_base = 1;

  initial begin
    int n, sz;
    bit acc, good;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        watching = 0;
        issue_cyc = -1;
        free_from = 0;
        e_instr = '0;
        e_cnt = '0;
        e_drop = 0;
        e_ie = 0;
        e_ready = 1;
        e_idle_base = 1;
      end else begin
        n = m_cyc;
        sz = mq.size();
        acc = bus.in_valid && (sz < DEPTH);
        good = acc && (bus.in_instr[63:60] == 4'h2) && (bus.in_instr[55:40] != 0);
        if (issue_cyc == n) begin
          void'(mq.pop_front());
          e_cnt = e_cnt + 16'd1;
          watching = 1;
          watch_from = n + 2;
          free_from = BIG;
        end
        if (watching && n >= watch_from && !bus.busy) begin
          watching = 0;
          free_from = n + 1;
        end
        if (!watching && issue_cyc != n && n >= free_from && bus.enable && sz > 0
            && !bus.busy && !bus.resource_busy) begin
          issue_cyc = n + 1;
          e_instr = mq[0];
        end
        if (good) mq.push_back(bus.in_instr);
        e_drop = acc && !good;
        m_cyc = n + 1;
        e_ie = (issue_cyc == m_cyc);
        e_ready = (mq.size() < DEPTH);
        e_idle_base = (mq.size() == 0) && !watching && (issue_cyc != m_cyc) && (m_cyc >= free_from);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("in_ready", bus.in_ready, e_ready);
        chk("instr_enable", bus.instr_enable, e_ie);
        chk("instr", bus.instr, e_instr);
        chk("drop_err", bus.drop_err, e_drop);
        chk("issued_count", bus.issued_count, e_cnt);
        chk("idle", bus.idle, e_idle_base && !bus.busy);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    int base, d0;
    logic [63:0] a_i, b_i, x;
    logic [63:0] fq[$];

    rst = 1;
    bus.enable = 0;
    bus.in_valid = 0;
    bus.in_instr = '0;
    bus.resource_busy = 0;
    #1 rst = 0;
    cmp_on = 1;
    repeat (3) tick();

    // reset values
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_instr_enable", bus.instr_enable, 0);
    chk("rst_instr", bus.instr, 64'h0);
    chk("rst_issued_count", bus.issued_count, 0);
    chk("rst_drop_err", bus.drop_err, 0);
    chk("rst_idle", bus.idle, 1);
    rst = 1;
    bus.enable = 1;
    tick();

    // single issue: strobe two cycles after the enqueue cycle
    ctrl_len = 3;
    a_i = mk(8'h23, 16'd29, 16'h0049, 24'h009463);
    try_send(a_i, acc);
    chk("single_accept", acc, 1);
    chk("single_early_ie", bus.instr_enable, 0);
    tick();
    chk("single_ie", bus.instr_enable, 1);
    chk("single_instr", bus.instr, 64'h23001d0049009463);
    tick();
    chk("single_ie_drop", bus.instr_enable, 0);
    chk("single_count", bus.issued_count, 1);
    chk("single_instr_hold", bus.instr, 64'h23001d0049009463);
    wait_idle(50);

    // back-to-back with 20-cycle busy after each issue
    ctrl_len = 20;
    base = iss_log.size();
    b_i = mk(8'h20, 16'd14, 16'h0006, 24'h0000AB);
    try_send(a_i, acc);
    try_send(b_i, acc);
    wait_issues(base + 2, 100);
    if (iss_log.size() >= base + 2) begin
      chk("b2b_gap", iss_cyc[base + 1] - iss_cyc[base], 23);
      chk("b2b_first", iss_log[base], a_i);
      chk("b2b_second", iss_log[base + 1], 64'h20000e00060000ab);
    end
    ctrl_len = 2;
    wait_idle(100);

    // full queue while the controller is held busy
    force_busy = 1;
    tick();
    tick();
    base = iss_log.size();
    fq.delete();
    for (int i = 0; i < 5; i++) begin
      x = mk({4'h2, 4'(i)}, 16'(i + 1), 16'(100 + i), 24'(i * 7));
      try_send(x, acc);
      chk("full_accept", acc, (i < 4) ? 1 : 0);
      if (i < 4) fq.push_back(x);
    end
    chk("full_no_issue", iss_log.size(), base);
    force_busy = 0;
    wait_issues(base + 4, 200);
    for (int i = 0; i < 4; i++) begin
      if (iss_log.size() > base + i) chk("full_order", iss_log[base + i], fq[i]);
    end
    wait_idle(100);

    // drops: wrong opcode class, zero length
    base = iss_log.size();
    d0 = drop_seen;
    try_send(mk(8'h10, 16'd5, 16'h0001, 24'h000002), acc);
    try_send(mk(8'h20, 16'd0, 16'h0003, 24'h000004), acc);
    repeat (4) tick();
    chk("drop_pulses", drop_seen - d0, 2);
    chk("drop_no_issue", iss_log.size(), base);
    chk("drop_count_kept", bus.issued_count, 7);

    // gating by enable and resource_busy
    bus.enable = 0;
    base = iss_log.size();
    a_i = mk(8'h2A, 16'd3, 16'h0010, 24'h000100);
    b_i = mk(8'h2B, 16'd4, 16'h0011, 24'h000101);
    try_send(a_i, acc);
    try_send(b_i, acc);
    repeat (10) tick();
    chk("gate_enable", iss_log.size(), base);
    bus.enable = 1;
    bus.resource_busy = 1;
    repeat (10) tick();
    chk("gate_resource", iss_log.size(), base);
    bus.resource_busy = 0;
    wait_issues(base + 2, 100);
    if (iss_log.size() >= base + 2) begin
      chk("gate_first", iss_log[base], a_i);
      chk("gate_second", iss_log[base + 1], b_i);
    end
    wait_idle(100);
    chk("gate_count", bus.issued_count, 9);

    // reset in WAIT_DONE with three instructions still queued
    ctrl_len = 10;
    base = iss_log.size();
    for (int i = 0; i < 4; i++) begin
      try_send(mk(8'h24, 16'(10 + i), 16'(i), 24'(i)), acc);
      chk("rmid_accept", acc, 1);
    end
    chk("rmid_one_issued", iss_log.size(), base + 1);
    rst = 0;
    #1;
    chk("rmid_ie", bus.instr_enable, 0);
    chk("rmid_in_ready", bus.in_ready, 1);
    chk("rmid_instr", bus.instr, 64'h0);
    chk("rmid_count", bus.issued_count, 0);
    chk("rmid_drop", bus.drop_err, 0);
    chk("rmid_idle_busy", bus.idle, 0);
    d0 = drop_seen;
    repeat (3) tick();
    chk("rmid_idle", bus.idle, 1);
    rst = 1;
    repeat (20) tick();
    chk("rmid_no_issue", iss_log.size(), base + 1);
    chk("rmid_no_drop", drop_seen, d0);
    chk("rmid_count_after", bus.issued_count, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 0;
        tick();
        tick();
        rst = 1;
      end
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.resource_busy = ($urandom_range(0, 7) == 0);
      force_busy = ($urandom_range(0, 15) == 0);
      ctrl_len = $urandom_range(0, 4);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_instr = mk({($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h2,
                         4'($urandom_range(0, 15))},
                        ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 65535)),
                        16'($urandom), 24'($urandom));
      tick();
    end

    bus.in_valid = 0;
    force_busy = 0;
    bus.enable = 1;
    bus.resource_busy = 0;
    repeat (2) tick();
    wait_idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
